// File: rtl/care_request_sequencer.sv
// rtl/care_request_sequencer.sv - request FIFO and issue sequencer in front of the customer care registry
module care_request_sequencer #(
  parameter int DEPTH         = 4,
  parameter int MAX_CUSTOMERS = 10,
  parameter int ID_W          = 8,
  parameter int DATA_W        = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ID_W-1:0]   req_id,
  input  logic [DATA_W-1:0] req_phone,
  input  logic [DATA_W-1:0] req_addr,
  output logic [ID_W-1:0]   reg_id,
  output logic [DATA_W-1:0] reg_phone,
  output logic [DATA_W-1:0] reg_addr,
  output logic              reg_add,
  output logic              reg_search,
  input  logic [ID_W-1:0]   reg_found_id,
  input  logic [DATA_W-1:0] reg_found_ph,
  input  logic [DATA_W-1:0] reg_found_ad,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_phone,
  output logic [DATA_W-1:0] rsp_addr,
  output logic [3:0]        add_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + ID_W + 2 * DATA_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]    MAX_CNT  = 4'(MAX_CUSTOMERS);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_MISS  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_BADID = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              req_ready_q, req_ready_d;
  state_t            state_q, state_d;
  logic              cur_op_q, cur_op_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [DATA_W-1:0] cur_phone_q, cur_phone_d;
  logic [DATA_W-1:0] cur_addr_q, cur_addr_d;
  logic [1:0]        status_q, status_d;
  logic [DATA_W-1:0] rsp_phone_q, rsp_phone_d;
  logic [DATA_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [3:0]        add_count_q, add_count_d;

  logic              push, pop;
  logic              rd_op;
  logic [ID_W-1:0]   rd_id;
  logic [DATA_W-1:0] rd_phone, rd_addr;
  logic              cur_bad, cur_full, hit;

  // req_ready is registered, so a push can never land on a full FIFO
  assign push     = req_valid && req_ready_q;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign {rd_op, rd_id, rd_phone, rd_addr} = mem_q[rd_ptr_q];
  // ID 0 marks an empty registry slot, so it can never be added or searched
  assign cur_bad  = (cur_id_q == '0);
  assign cur_full = (add_count_q == MAX_CNT);
  assign hit      = (reg_found_id == cur_id_q);

  // FIFO storage; entries are only read while count guards them, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_op, req_id, req_phone, req_addr};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    req_ready_d = (count_d != FULL_CNT);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_ISSUE;
      S_ISSUE: state_d = (cur_op_q && !cur_bad) ? S_WAIT : S_RESP;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs toward the registry and the host
  always_comb begin
    reg_add    = (state_q == S_ISSUE) && !cur_op_q && !cur_bad && !cur_full;
    reg_search = cur_op_q && !cur_bad && ((state_q == S_ISSUE) || (state_q == S_WAIT));
    rsp_valid  = (state_q == S_RESP);
  end

  // Current request, status and response data
  always_comb begin
    cur_op_d    = cur_op_q;
    cur_id_d    = cur_id_q;
    cur_phone_d = cur_phone_q;
    cur_addr_d  = cur_addr_q;
    status_d    = status_q;
    rsp_phone_d = rsp_phone_q;
    rsp_addr_d  = rsp_addr_q;
    add_count_d = add_count_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_op_d    = rd_op;
          cur_id_d    = rd_id;
          cur_phone_d = rd_phone;
          cur_addr_d  = rd_addr;
          status_d    = ST_OK;
          rsp_phone_d = '0;
          rsp_addr_d  = '0;
        end
      end
      S_ISSUE: begin
        if (cur_bad) begin
          status_d = ST_BADID;
        end else if (!cur_op_q) begin
          if (cur_full) begin
            status_d = ST_FULL;
          end else begin
            status_d    = ST_OK;
            add_count_d = add_count_q + 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (hit) begin
          status_d    = ST_OK;
          rsp_phone_d = reg_found_ph;
          rsp_addr_d  = reg_found_ad;
        end else begin
          status_d = ST_MISS;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset aborts any in-flight request and empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b0;
      state_q     <= S_IDLE;
      cur_op_q    <= 1'b0;
      cur_id_q    <= '0;
      cur_phone_q <= '0;
      cur_addr_q  <= '0;
      status_q    <= ST_OK;
      rsp_phone_q <= '0;
      rsp_addr_q  <= '0;
      add_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      state_q     <= state_d;
      cur_op_q    <= cur_op_d;
      cur_id_q    <= cur_id_d;
      cur_phone_q <= cur_phone_d;
      cur_addr_q  <= cur_addr_d;
      status_q    <= status_d;
      rsp_phone_q <= rsp_phone_d;
      rsp_addr_q  <= rsp_addr_d;
      add_count_q <= add_count_d;
    end
  end

  // Registry operands come straight from the held request, so they only change on a pop
  assign req_ready  = req_ready_q;
  assign reg_id     = cur_id_q;
  assign reg_phone  = cur_phone_q;
  assign reg_addr   = cur_addr_q;
  assign rsp_status = status_q;
  assign rsp_id     = cur_id_q;
  assign rsp_phone  = rsp_phone_q;
  assign rsp_addr   = rsp_addr_q;
  assign add_count  = add_count_q;

endmodule

// File: tb/tb_care_request_sequencer.sv
// tb/tb_care_request_sequencer.sv - directed self-checking bench for care_request_sequencer
module tb_care_request_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_op = 1'b0;
  logic [7:0]   req_id = '0;
  logic [127:0] req_phone = '0;
  logic [127:0] req_addr = '0;
  logic [7:0]   reg_id;
  logic [127:0] reg_phone, reg_addr;
  logic         reg_add, reg_search;
  logic [7:0]   reg_found_id;
  logic [127:0] reg_found_ph, reg_found_ad;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_status;
  logic [7:0]   rsp_id;
  logic [127:0] rsp_phone, rsp_addr;
  logic [3:0]   add_count;

  int tests_run = 0;
  int tests_failed = 0;
  int add_pulses = 0;
  int search_cycles = 0;

  // Small registry stand-in: ten slots, registered search result
  logic [7:0]   m_id [10];
  logic [127:0] m_ph [10];
  logic [127:0] m_ad [10];
  int           m_n;

  care_request_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
    .req_phone(req_phone), .req_addr(req_addr),
    .reg_id(reg_id), .reg_phone(reg_phone), .reg_addr(reg_addr),
    .reg_add(reg_add), .reg_search(reg_search),
    .reg_found_id(reg_found_id), .reg_found_ph(reg_found_ph), .reg_found_ad(reg_found_ad),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_id(rsp_id),
    .rsp_phone(rsp_phone), .rsp_addr(rsp_addr), .add_count(add_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) begin
        m_id[i] <= '0;
        m_ph[i] <= '0;
        m_ad[i] <= '0;
      end
      m_n          <= 0;
      reg_found_id <= '0;
      reg_found_ph <= '0;
      reg_found_ad <= '0;
    end else begin
      if (reg_add && m_n < 10) begin
        m_id[m_n] <= reg_id;
        m_ph[m_n] <= reg_phone;
        m_ad[m_n] <= reg_addr;
        m_n       <= m_n + 1;
      end
      if (reg_search) begin
        reg_found_id <= '0;
        reg_found_ph <= '0;
        reg_found_ad <= '0;
        for (int i = 0; i < 10; i++) begin
          if (m_id[i] == reg_id && m_id[i] != 8'd0) begin
            reg_found_id <= m_id[i];
            reg_found_ph <= m_ph[i];
            reg_found_ad <= m_ad[i];
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reg_add)    add_pulses    <= add_pulses + 1;
    if (reg_search) search_cycles <= search_cycles + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic op, input logic [7:0] id, input logic [127:0] ph, input logic [127:0] ad);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_id    = id;
    req_phone = ph;
    req_addr  = ad;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", (n < 50), 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int exp_lat, input logic [1:0] st,
                            input logic [7:0] id, input logic [127:0] ph, input logic [127:0] ad);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1'b1);
    if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
    check({tag, "_status"}, rsp_status, st);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_phone"}, rsp_phone, ph);
    check({tag, "_addr"}, rsp_addr, ad);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int p0, s0;
    logic [7:0] ids5 [5];
    logic [1:0] st5 [5];

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_reg_add", reg_add, 1'b0);
    check("rst_add_count", add_count, 4'd0);
    check("rst_reg_id", reg_id, 8'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", req_ready, 1'b1);

    // Test 1: add id 5
    p0 = add_pulses;
    push(1'b0, 8'd5, 128'h11, 128'h22);
    check("t1_no_early_rsp", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    check("t1_reg_add", reg_add, 1'b1);
    check("t1_reg_id", reg_id, 8'd5);
    check("t1_reg_phone", reg_phone, 128'h11);
    check("t1_reg_addr", reg_addr, 128'h22);
    @(posedge clk);
    #1;
    check("t1_reg_add_end", reg_add, 1'b0);
    expect_rsp("t1", 0, 2'b00, 8'd5, 128'h0, 128'h0);
    check("t1_pulses", add_pulses - p0, 1);
    check("t1_add_count", add_count, 4'd1);

    // Test 2: search hit and miss
    push(1'b1, 8'd5, '0, '0);
    expect_rsp("t2_hit", 3, 2'b00, 8'd5, 128'h11, 128'h22);
    push(1'b1, 8'd9, '0, '0);
    expect_rsp("t2_miss", 3, 2'b01, 8'd9, 128'h0, 128'h0);

    // Test 4: reserved id 0
    p0 = add_pulses;
    s0 = search_cycles;
    push(1'b0, 8'd0, 128'h33, 128'h44);
    expect_rsp("t4_add0", 2, 2'b11, 8'd0, 128'h0, 128'h0);
    push(1'b1, 8'd0, '0, '0);
    expect_rsp("t4_srch0", 2, 2'b11, 8'd0, 128'h0, 128'h0);
    check("t4_no_pulse", add_pulses - p0, 0);
    check("t4_no_search", search_cycles - s0, 0);
    check("t4_add_count", add_count, 4'd1);

    // Test 3: fill registry from fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t3_count_clr", add_count, 4'd0);
    p0 = add_pulses;
    for (int i = 1; i <= 11; i++) begin
      push(1'b0, 8'(i), 128'h100 + 128'(i), 128'h200 + 128'(i));
      expect_rsp("t3_add", 2, (i <= 10) ? 2'b00 : 2'b10, 8'(i), 128'h0, 128'h0);
    end
    check("t3_pulses", add_pulses - p0, 10);
    check("t3_add_count", add_count, 4'd10);

    // Test 5: backpressure with five queued searches
    ids5[0] = 8'd3;  st5[0] = 2'b00;
    ids5[1] = 8'd11; st5[1] = 2'b01;
    ids5[2] = 8'd1;  st5[2] = 2'b00;
    ids5[3] = 8'd10; st5[3] = 2'b00;
    ids5[4] = 8'd7;  st5[4] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("t5_ready_before_5th", req_ready, 1'b1);
      push(1'b1, ids5[i], '0, '0);
    end
    check("t5_ready_low", req_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_ready_held_low", req_ready, 1'b0);
    check("t5_rsp_held", rsp_valid, 1'b1);
    check("t5_rsp_first_id", rsp_id, 8'd3);
    for (int i = 0; i < 5; i++) begin
      expect_rsp("t5_rsp", -1, st5[i], ids5[i],
                 (st5[i] == 2'b00) ? 128'h100 + 128'(ids5[i]) : 128'h0,
                 (st5[i] == 2'b00) ? 128'h200 + 128'(ids5[i]) : 128'h0);
    end
    check("t5_ready_back", req_ready, 1'b1);

    // Test 6: reset during WAIT of a search
    push(1'b1, 8'd2, '0, '0);
    @(posedge clk);
    #1;
    check("t6_issue_search", reg_search, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_rsp_valid", rsp_valid, 1'b0);
    check("t6_rst_search", reg_search, 1'b0);
    check("t6_rst_ready", req_ready, 1'b0);
    check("t6_rst_count", add_count, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_ready_rise", req_ready, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_response", rsp_valid, 1'b0);
    push(1'b0, 8'd7, 128'h77, 128'h78);
    expect_rsp("t6_add", 2, 2'b00, 8'd7, 128'h0, 128'h0);
    check("t6_add_count", add_count, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
